// File: rtl/filter_sched_if.sv
// Bundle of the requester-side and filter-side signals of the filter scheduler.
// The slave modport is the scheduler; the master modport is its environment.
interface filter_sched_if #(
  parameter int NCH = 4,
  parameter int W   = 32
);
  logic [NCH-1:0]   req;
  logic [NCH*W-1:0] req_x;
  logic [NCH-1:0]   gnt;
  logic [NCH-1:0]   resp_valid;
  logic [NCH-1:0]   resp_err;
  logic [W-1:0]     resp_y;
  logic [15:0]      done_cnt;
  logic [W-1:0]     f_x;
  logic             f_start;
  logic             f_ready;
  logic             f_valid;
  logic [W-1:0]     f_y;

  modport slave (
    input  req, req_x, f_ready, f_valid, f_y,
    output gnt, resp_valid, resp_err, resp_y, done_cnt, f_x, f_start
  );

  modport master (
    output req, req_x, f_ready, f_valid, f_y,
    input  gnt, resp_valid, resp_err, resp_y, done_cnt, f_x, f_start
  );
endinterface

// File: rtl/filter_sched.sv
// Round-robin scheduler sharing one filter datapath among NCH requesters,
// with a per-job timeout and one-hot result/error pulses back to the requester.
module filter_sched #(
  parameter int NCH     = 4,
  parameter int W       = 32,
  parameter int TIMEOUT = 64
) (
  input  logic          i_clk,
  input  logic          i_rst,
  filter_sched_if.slave bus
);
  localparam int CW = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } state_t;

  state_t         r_state;
  logic [CW-1:0]  r_ptr;
  logic [NCH-1:0] r_ch_oh;
  logic [TW-1:0]  r_timer;
  logic [NCH-1:0] r_gnt;
  logic [NCH-1:0] r_resp_valid;
  logic [NCH-1:0] r_resp_err;
  logic [W-1:0]   r_resp_y;
  logic [15:0]    r_done_cnt;
  logic [W-1:0]   r_f_x;
  logic           r_f_start;

  logic [W-1:0]   w_x [NCH];
  logic           w_pick_vld;
  logic [CW-1:0]  w_pick_ch;
  logic [CW-1:0]  w_idx;
  int             w_sum;
  logic [NCH-1:0] w_pick_oh;
  logic [CW-1:0]  w_ptr_nxt;

  for (genvar c = 0; c < NCH; c++) begin : g_unpack
    assign w_x[c] = bus.req_x[c*W +: W];
  end

  // First requester at or after r_ptr, wrapping modulo NCH.
  always_comb begin
    w_pick_vld = 1'b0;
    w_pick_ch  = '0;
    w_idx      = '0;
    w_sum      = 0;
    for (int i = 0; i < NCH; i++) begin
      w_sum = int'(r_ptr) + i;
      if (w_sum >= NCH) begin
        w_idx = CW'(w_sum - NCH);
      end else begin
        w_idx = CW'(w_sum);
      end
      if (!w_pick_vld && bus.req[w_idx]) begin
        w_pick_vld = 1'b1;
        w_pick_ch  = w_idx;
      end else begin
        w_pick_vld = w_pick_vld;
      end
    end
  end

  assign w_pick_oh = {{(NCH-1){1'b0}}, 1'b1} << w_pick_ch;

  always_comb begin
    if (w_pick_ch == CW'(NCH - 1)) begin
      w_ptr_nxt = '0;
    end else begin
      w_ptr_nxt = w_pick_ch + CW'(1);
    end
  end

  // Job sequencer; every output is a flop set on the transition into its state.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_state      <= ST_IDLE;
      r_ptr        <= '0;
      r_ch_oh      <= '0;
      r_timer      <= '0;
      r_gnt        <= '0;
      r_resp_valid <= '0;
      r_resp_err   <= '0;
      r_resp_y     <= '0;
      r_done_cnt   <= 16'd0;
      r_f_x        <= '0;
      r_f_start    <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_resp_valid <= '0;
          r_resp_err   <= '0;
          if (bus.f_ready && w_pick_vld) begin
            r_ch_oh   <= w_pick_oh;
            r_f_x     <= w_x[w_pick_ch];
            r_ptr     <= w_ptr_nxt;
            r_gnt     <= w_pick_oh;
            r_f_start <= 1'b1;
            r_state   <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          r_gnt     <= '0;
          r_f_start <= 1'b0;
          r_timer   <= '0;
          r_state   <= ST_WAIT;
        end
        ST_WAIT: begin
          // A result arriving on the expiry cycle still counts as success.
          if (bus.f_valid) begin
            r_resp_y     <= bus.f_y;
            r_resp_valid <= r_ch_oh;
            r_done_cnt   <= r_done_cnt + 16'd1;
            r_state      <= ST_RESP;
          end else if (r_timer == TW'(TIMEOUT - 1)) begin
            r_resp_err <= r_ch_oh;
            r_state    <= ST_RESP;
          end else begin
            r_timer <= r_timer + TW'(1);
          end
        end
        ST_RESP: begin
          r_resp_valid <= '0;
          r_resp_err   <= '0;
          r_state      <= ST_IDLE;
        end
        default: begin
          r_gnt        <= '0;
          r_f_start    <= 1'b0;
          r_resp_valid <= '0;
          r_resp_err   <= '0;
          r_state      <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.gnt        = r_gnt;
  assign bus.resp_valid = r_resp_valid;
  assign bus.resp_err   = r_resp_err;
  assign bus.resp_y     = r_resp_y;
  assign bus.done_cnt   = r_done_cnt;
  assign bus.f_x        = r_f_x;
  assign bus.f_start    = r_f_start;
endmodule
